hs32_lsu: RTL and testbench

HS32_LSU -- requirements
Module: hs32_lsu

---
 rtl/hs32_lsu.sv | 190 +++++++++++++++++++
 tb/tb_hs32_lsu.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs32_lsu.sv
// Load/store unit: queues byte/half/word requests and runs them one at a time on a strobe/ack bus.
// Latency: queue entry to rsp_valid is 3 cycles minimum (IDLE, STB, RSP); misaligned requests fault in 2.
// Backpressure: rdy drops when the queue is full; stlm holds the strobe, ackm completes the access.
module hs32_lsu #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int TW    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  output logic            rdy,
  input  logic            req_rw,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_data,
  input  logic [1:0]      req_size,
  input  logic            req_sext,
  input  logic [TW-1:0]   req_tag,
  input  logic            flush,
  output logic            rsp_valid,
  output logic [DW-1:0]   rsp_data,
  output logic [TW-1:0]   rsp_tag,
  output logic            rsp_fault,
  output logic [AW-1:0]   addr,
  output logic [DW-1:0]   dtwm,
  input  logic [DW-1:0]   dtrm,
  output logic [DW/8-1:0] sel,
  output logic            stbm,
  input  logic            stlm,
  input  logic            ackm,
  output logic            rw_mem
);

  localparam int NB = DW / 8;
  localparam int OW = $clog2(NB);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 1 + AW + DW + 2 + 1 + TW;

  typedef enum logic [1:0] {S_IDLE, S_STB, S_ACK, S_RSP} state_t;

  state_t state, state_nxt;

  // request queue
  logic [EW-1:0] qmem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          enq, pop;

  // queue head fields
  logic          h_rw;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_data;
  logic [1:0]    h_size;
  logic          h_sext;
  logic [TW-1:0] h_tag;
  logic [OW-1:0] h_off;
  logic          h_mis;
  logic [NB-1:0] h_mask;

  // in-flight access context
  logic [TW-1:0] cur_tag;
  logic [1:0]    cur_size;
  logic          cur_sext;
  logic [OW-1:0] cur_off;
  logic          cur_fault;
  logic          cur_rw;
  logic          kill;
  logic [DW-1:0] rdata;
  logic [DW-1:0] shifted;
  logic [DW-1:0] ld;

  assign rdy = count < CW'(DEPTH);
  // flush takes priority over a same-cycle enqueue and blocks issue from the queue
  assign enq = req && rdy && !flush;
  assign pop = (state == S_IDLE) && (count != '0) && !flush;

  assign {h_rw, h_addr, h_data, h_size, h_sext, h_tag} = qmem[rd_ptr];
  assign h_off = h_addr[OW-1:0];

  // misalignment and byte-lane mask of the queue head
  always_comb begin
    h_mis  = 1'b0;
    h_mask = '0;
    if (h_size == 2'd1 && h_addr[0]) h_mis = 1'b1;
    if (h_size[1] && h_addr[1:0] != 2'b00) h_mis = 1'b1;
    h_mask[0] = 1'b1;
    if (h_size != 2'd0) h_mask[1] = 1'b1;
    if (h_size[1]) h_mask = '1;
  end

  // queue pointers and occupancy; flush empties the queue in one edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(enq) - CW'(pop);
    end
  end

  // queue storage; contents are only meaningful below count, so no reset
  always_ff @(posedge clk) begin
    if (enq) qmem[wr_ptr] <= {req_rw, req_addr, req_data, req_size, req_sext, req_tag};
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (pop) state_nxt = h_mis ? S_RSP : S_STB;
      S_STB:  if (!stlm) state_nxt = ackm ? S_RSP : S_ACK;
      S_ACK:  if (ackm) state_nxt = S_RSP;
      S_RSP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // bus outputs and access context, loaded only on issue so they hold still under the strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr      <= '0;
      dtwm      <= '0;
      sel       <= '0;
      rw_mem    <= 1'b0;
      cur_tag   <= '0;
      cur_size  <= '0;
      cur_sext  <= 1'b0;
      cur_off   <= '0;
      cur_fault <= 1'b0;
      cur_rw    <= 1'b0;
      kill      <= 1'b0;
      rdata     <= '0;
    end else begin
      if (pop) begin
        cur_tag   <= h_tag;
        cur_size  <= h_size;
        cur_sext  <= h_sext;
        cur_off   <= h_off;
        cur_fault <= h_mis;
        cur_rw    <= h_rw;
        kill      <= 1'b0;
        if (!h_mis) begin
          addr   <= {h_addr[AW-1:OW], {OW{1'b0}}};
          dtwm   <= h_data << {h_off, 3'b000};
          sel    <= h_mask << h_off;
          rw_mem <= h_rw;
        end
      end
      if (((state == S_STB && !stlm) || state == S_ACK) && ackm) rdata <= dtrm;
      // a flushed access still finishes on the bus but must not answer upstream
      if (flush && (state == S_STB || state == S_ACK)) kill <= 1'b1;
    end
  end

  // align the captured read data to bit 0 and extend to the full width
  always_comb begin
    shifted = rdata >> {cur_off, 3'b000};
    ld      = shifted;
    if (cur_size == 2'd0) begin
      for (int i = 8; i < DW; i++) ld[i] = cur_sext & shifted[7];
    end else if (cur_size == 2'd1) begin
      for (int i = 16; i < DW; i++) ld[i] = cur_sext & shifted[15];
    end
  end

  // state-decoded outputs; response fields read zero outside a delivered response
  always_comb begin
    stbm      = (state == S_STB);
    rsp_valid = (state == S_RSP) && !kill;
    rsp_tag   = rsp_valid ? cur_tag : '0;
    rsp_fault = rsp_valid & cur_fault;
    rsp_data  = (rsp_valid && !cur_rw && !cur_fault) ? ld : '0;
  end

endmodule

// File: tb/tb_hs32_lsu.sv
// Bench for hs32_lsu: vector table of single accesses plus hand sequences for stalls,
// queue fill/flush and reset mid-access. Responses are matched against a queue of
// expected results pushed at the moment each request is driven.
module tb_hs32_lsu;
  localparam int AW = 32, DW = 32, DEPTH = 4, TW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req, rdy, req_rw, req_sext, flush;
  logic [31:0]   req_addr, req_data;
  logic [1:0]    req_size;
  logic [3:0]    req_tag;
  logic          rsp_valid, rsp_fault;
  logic [31:0]   rsp_data;
  logic [3:0]    rsp_tag;
  logic [31:0]   addr, dtwm, dtrm;
  logic [3:0]    sel;
  logic          stbm, stlm, ackm, rw_mem;

  hs32_lsu #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .TW(TW)) dut (
    .clk(clk), .reset(reset), .req(req), .rdy(rdy), .req_rw(req_rw),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .req_sext(req_sext), .req_tag(req_tag), .flush(flush),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_fault(rsp_fault), .addr(addr), .dtwm(dtwm), .dtrm(dtrm), .sel(sel),
    .stbm(stbm), .stlm(stlm), .ackm(ackm), .rw_mem(rw_mem)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] data;
    logic        fault;
  } rsp_t;

  typedef struct {
    logic        rw;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  sz;
    logic        sx;
    logic [3:0]  tag;
    logic [31:0] mem;
    logic [31:0] e_addr;
    logic [3:0]  e_sel;
    logic [31:0] e_dtwm;
    logic [31:0] e_rsp;
    logic        e_fault;
  } vec_t;

  rsp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic rw, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input logic sx, input logic [3:0] tg);
    req = 1'b1; req_rw = rw; req_addr = a; req_data = d;
    req_size = sz; req_sext = sx; req_tag = tg;
    step;
    req = 1'b0;
  endtask

  function automatic vec_t mk(input logic rw, input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] sz, input logic sx, input logic [3:0] tag,
                              input logic [31:0] mem, input logic [31:0] e_addr,
                              input logic [3:0] e_sel, input logic [31:0] e_dtwm,
                              input logic [31:0] e_rsp, input logic e_fault);
    vec_t v;
    v.rw = rw; v.a = a; v.d = d; v.sz = sz; v.sx = sx; v.tag = tag; v.mem = mem;
    v.e_addr = e_addr; v.e_sel = e_sel; v.e_dtwm = e_dtwm; v.e_rsp = e_rsp; v.e_fault = e_fault;
    return v;
  endfunction

  // response scoreboard
  always @(negedge clk) begin : mon
    rsp_t e;
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got tag %h, required no response", rsp_tag);
      end else begin
        e = sb.pop_front();
        chk("rsp_tag", {28'd0, rsp_tag}, {28'd0, e.tag});
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_fault", {31'd0, rsp_fault}, {31'd0, e.fault});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish within budget");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[13];
    int   n, acc;
    logic saw_stb, saw_rsp;

    //           rw    addr        data          sz  sx tag    dtrm          e_addr      sel    e_dtwm        e_rsp         flt
    vt[0]  = mk(1'b0, 32'h100, 32'h0,         2, 0, 4'h3, 32'hDEADBEEF, 32'h100, 4'hF, 32'h0,        32'hDEADBEEF, 0);
    vt[1]  = mk(1'b0, 32'h103, 32'h0,         0, 1, 4'h1, 32'h80000000, 32'h100, 4'h8, 32'h0,        32'hFFFFFF80, 0);
    vt[2]  = mk(1'b0, 32'h103, 32'h0,         0, 0, 4'h2, 32'h80000000, 32'h100, 4'h8, 32'h0,        32'h00000080, 0);
    vt[3]  = mk(1'b0, 32'h202, 32'h0,         1, 1, 4'h4, 32'h80011234, 32'h200, 4'hC, 32'h0,        32'hFFFF8001, 0);
    vt[4]  = mk(1'b0, 32'h000, 32'h0,         1, 0, 4'h5, 32'h1234F00D, 32'h000, 4'h3, 32'h0,        32'h0000F00D, 0);
    vt[5]  = mk(1'b1, 32'h301, 32'hAB,        0, 0, 4'h6, 32'h11111111, 32'h300, 4'h2, 32'h0000AB00, 32'h0,        0);
    vt[6]  = mk(1'b1, 32'h404, 32'hCAFEF00D,  2, 0, 4'h7, 32'h22222222, 32'h404, 4'hF, 32'hCAFEF00D, 32'h0,        0);
    vt[7]  = mk(1'b0, 32'h101, 32'h0,         2, 0, 4'h8, 32'h0,        32'h0,   4'h0, 32'h0,        32'h0,        1);
    vt[8]  = mk(1'b0, 32'h203, 32'h0,         1, 0, 4'h9, 32'h0,        32'h0,   4'h0, 32'h0,        32'h0,        1);
    vt[9]  = mk(1'b1, 32'h102, 32'h5,         2, 0, 4'hA, 32'h0,        32'h0,   4'h0, 32'h0,        32'h0,        1);
    vt[10] = mk(1'b0, 32'h102, 32'h0,         0, 0, 4'hB, 32'h00FF0000, 32'h100, 4'h4, 32'h0,        32'h000000FF, 0);
    vt[11] = mk(1'b0, 32'h102, 32'h0,         0, 1, 4'hC, 32'h00FF0000, 32'h100, 4'h4, 32'h0,        32'hFFFFFFFF, 0);
    vt[12] = mk(1'b1, 32'h206, 32'hBEEF,      1, 0, 4'hD, 32'h0,        32'h204, 4'hC, 32'hBEEF0000, 32'h0,        0);

    reset = 1'b1; req = 1'b0; req_rw = 1'b0; req_addr = '0; req_data = '0;
    req_size = '0; req_sext = 1'b0; req_tag = '0; flush = 1'b0;
    dtrm = '0; stlm = 1'b0; ackm = 1'b0;

    // reset state
    step; step;
    chk("rst_stbm", {31'd0, stbm}, 0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_tag", {28'd0, rsp_tag}, 0);
    chk("rst_addr", addr, 0);
    chk("rst_sel", {28'd0, sel}, 0);
    chk("rst_dtwm", dtwm, 0);
    chk("rst_rw_mem", {31'd0, rw_mem}, 0);
    reset = 1'b0;
    step;
    chk("rst_rdy", {31'd0, rdy}, 1);

    // single accesses; ackm arrives the cycle after the strobe
    for (int i = 0; i < 13; i++) begin
      sb.push_back('{tag: vt[i].tag, data: vt[i].e_rsp, fault: vt[i].e_fault});
      send(vt[i].rw, vt[i].a, vt[i].d, vt[i].sz, vt[i].sx, vt[i].tag);
      if (vt[i].e_fault) begin
        // enqueue cycle, IDLE, then the fault response in the third cycle
        step;
        chk("fault_no_stbm", {31'd0, stbm}, 0);
        chk("fault_latency", sb.size(), 0);
        step;
      end else begin
        step;
        chk("vec_stbm", {31'd0, stbm}, 1);
        chk("vec_addr", addr, vt[i].e_addr);
        chk("vec_sel", {28'd0, sel}, {28'd0, vt[i].e_sel});
        chk("vec_dtwm", dtwm, vt[i].e_dtwm);
        chk("vec_rw_mem", {31'd0, rw_mem}, {31'd0, vt[i].rw});
        step;
        chk("vec_stbm_drop", {31'd0, stbm}, 0);
        dtrm = vt[i].mem; ackm = 1'b1;
        step;
        ackm = 1'b0; dtrm = '0;
        chk("vec_rsp_seen", sb.size(), 0);
        step;
      end
      if (sb.size() != 0) sb.delete();
    end

    // minimum latency: ackm together with the strobe
    sb.push_back('{tag: 4'hE, data: 32'h13579BDF, fault: 1'b0});
    send(1'b0, 32'h500, 32'h0, 2, 0, 4'hE);
    step;
    stlm = 1'b0; ackm = 1'b1; dtrm = 32'h13579BDF;
    step;
    ackm = 1'b0; dtrm = '0;
    chk("min_latency", sb.size(), 0);
    step;

    // half store with two stall cycles: strobe held three cycles, bus fields stable
    sb.push_back('{tag: 4'h2, data: 32'h0, fault: 1'b0});
    send(1'b1, 32'h202, 32'h1234, 1, 0, 4'h2);
    step;
    n = 0;
    for (int g = 0; g < 10 && stbm; g++) begin
      n++;
      chk("st_addr", addr, 32'h200);
      chk("st_sel", {28'd0, sel}, 32'hC);
      chk("st_dtwm", dtwm, 32'h12340000);
      chk("st_rw_mem", {31'd0, rw_mem}, 1);
      stlm = (n <= 2);
      ackm = (n > 2);
      step;
    end
    stlm = 1'b0; ackm = 1'b0;
    chk("stb_hold_cycles", n, 3);
    chk("store_rsp", sb.size(), 0);
    step;

    // fill the queue with the bus never acknowledging, then flush during ACK
    acc = 0;
    req_rw = 1'b0; req_size = 2; req_sext = 1'b0; req_data = '0;
    for (int k = 0; k < DEPTH + 2; k++) begin
      req = 1'b1;
      req_addr = 32'h600 + 32'(4 * k);
      req_tag = 4'(k);
      if (rdy) acc++;
      step;
    end
    req = 1'b0;
    chk("fill_accepted", acc, DEPTH + 1);
    chk("fill_rdy_low", {31'd0, rdy}, 0);
    chk("fill_in_ack", {31'd0, stbm}, 0);
    flush = 1'b1;
    step;
    flush = 1'b0;
    chk("flush_rdy", {31'd0, rdy}, 1);
    ackm = 1'b1;
    step;
    ackm = 1'b0;
    saw_stb = 1'b0; saw_rsp = 1'b0;
    for (int k = 0; k < 6; k++) begin
      saw_stb |= stbm;
      saw_rsp |= rsp_valid;
      step;
    end
    chk("flush_rsp_suppressed", {31'd0, saw_rsp}, 0);
    chk("flush_queue_empty", {31'd0, saw_stb}, 0);

    // flush and enqueue in the same cycle: request is dropped
    req = 1'b1; flush = 1'b1; req_addr = 32'h700; req_tag = 4'h9;
    step;
    req = 1'b0; flush = 1'b0;
    saw_stb = 1'b0;
    for (int k = 0; k < 5; k++) begin
      saw_stb |= stbm;
      step;
    end
    chk("flush_enq_dropped", {31'd0, saw_stb}, 0);

    // reset during STB with ackm pending across release
    send(1'b1, 32'h800, 32'h55, 2, 0, 4'hF);
    step;
    chk("pre_rst_stbm", {31'd0, stbm}, 1);
    reset = 1'b1; ackm = 1'b1;
    #1;
    chk("async_rst_stbm", {31'd0, stbm}, 0);
    chk("async_rst_addr", addr, 0);
    chk("async_rst_sel", {28'd0, sel}, 0);
    chk("async_rst_rw_mem", {31'd0, rw_mem}, 0);
    step;
    reset = 1'b0;
    saw_stb = 1'b0; saw_rsp = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) ackm = 1'b0;
      saw_stb |= stbm;
      saw_rsp |= rsp_valid;
      step;
    end
    chk("post_rst_no_rsp", {31'd0, saw_rsp}, 0);
    chk("post_rst_no_stbm", {31'd0, saw_stb}, 0);
    chk("post_rst_rdy", {31'd0, rdy}, 1);

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
